ahb_lite_decmux: RTL and testbench
==================================

# ahb_lite_decmux

Parametrised AHB-Lite address decoder and slave-response multiplexer for N slaves with a built-in default slave. Sits between one master, or an arbiter output, and up to N_SLV slaves on the shared address/control bus. Drives per-slave HSEL and the global HREADY, and returns the selected slave's data-phase response to the master. Tracks the address/data pipeline so data-phase responses are routed from the slave selected in the previous accepted address phase.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- N_SLV, 4, number of slaves (1..16).
- HRESP_W, 2, response width; OKAY=0, ERROR=1.
- SLV_BASE, {N_SLV{ADDR_W'0}}, flattened N_SLV×ADDR_W region base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W].
- SLV_MASK, {N_SLV{ADDR_W'0}}, flattened region masks; slave i hits when (HADDR & MASK_i) == BASE_i.
- TIMEOUT_CYC, 256, wait-state limit; used only with the timeout feature.

Ports:
- HCLK  in  1  clock; all state updates on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HADDR  in  ADDR_W  master address.
- HTRANS  in  2  master transfer type.
- HSEL  out  N_SLV  one-hot slave select (combinational decode).
- HREADY  out  1  global ready, driven to the master and all slaves.
- HRESP  out  HRESP_W  response to the master.
- HRDATA  out  DATA_W  read data to the master.
- S_HREADYOUT  in  N_SLV  per-slave ready.
- S_HRESP  in  N_SLV*HRESP_W  per-slave response, flattened.
- S_HRDATA  in  N_SLV*DATA_W  per-slave read data, flattened.
- TIMEOUT_ERR  out  1  sticky timeout flag.

## Operation
- Decode: a slave hits when (HADDR & MASK_i) == BASE_i; the lowest index wins on overlap. If no slave hits, the default slave (DEF) is selected and HSEL = 0.
- HSEL asserts for all HTRANS values, including IDLE and BUSY.
- Data-phase state:
  - The data-phase state is a slave index `dsel` (0..N_SLV-1 or DEF) plus a flag `dact`.
  - Both update only when HREADY=1: `dsel` takes the current decode; `dact` takes HTRANS[1], i.e. 1 for NONSEQ/SEQ.
- Response mux:
  - `dact`=0: HREADY=1, HRESP=OKAY, HRDATA=0.
  - `dact`=1 with `dsel`=i: forward S_HREADYOUT[i], S_HRESP[i], S_HRDATA[i].
  - `dact`=1 with `dsel`=DEF: response comes from the default-slave FSM.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE→ERR1 when `dact` becomes 1 with `dsel`=DEF. ERR1 drives HREADY=0, HRESP=ERROR.
  - ERR1→ERR2 unconditionally. ERR2 drives HREADY=1, HRESP=ERROR.
  - ERR2→ERR1 if the transfer accepted during ERR2 is NONSEQ/SEQ to unmapped space; otherwise ERR2→IDLE.
- IDLE/BUSY transfers to unmapped space produce a zero-wait OKAY.
- Slave ERROR responses pass through unchanged, including both cycles of the two-cycle ERROR.

## Timing
- Decode and HSEL are combinational from HADDR. The response mux is combinational from registered state. The block adds zero cycles of latency.
- An address phase in cycle N gets its data phase in cycle N+1 onward; the data phase ends on the first cycle with HREADY=1.
- While HREADY=0, `dsel` and `dact` hold, and HSEL keeps following the held address.
- Default-slave ERROR takes exactly 2 cycles: HREADY=0 then HREADY=1.
- Reset values: `dact`=0, `dsel`=0, FSM=IDLE, wait counter=0, TIMEOUT_ERR=0. Outputs after reset: HREADY=1, HRESP=OKAY, HRDATA=0.
- Reset mid-transfer abandons the data phase. The first cycle after reset shows HREADY=1.
- Back-to-back transfers to different slaves: the cycle-N address phase goes to slave B while the data-phase response still comes from slave A.

## Configuration
- With `KVIPS_AHB_DECMUX_TIMEOUT_EN` defined:
  - A counter clears on every HREADY=1 cycle and increments while `dact`=1 and HREADY=0, saturating at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC, TIMEOUT_ERR sets and stays set until HRESET.
  - Bus behaviour is unchanged.
- Without the macro: no counter is built, TIMEOUT_ERR is tied to 0, and TIMEOUT_CYC is ignored.

## Test plan
- Decode and forward, with N_SLV=4, regions 0x0000_0000/0x1000_0000/0x2000_0000/0x3000_0000 and mask 0xF000_0000:
  - NONSEQ read at 0x2000_0040 → HSEL=4'b0100 in the address cycle.
  - Next cycle, with S_HRDATA[2]=0xDEAD_BEEF, HRDATA=0xDEAD_BEEF, HRESP=OKAY.
- Unmapped access: NONSEQ to 0x8000_0000 → HSEL=0; next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then IDLE. An IDLE transfer to 0x8000_0000 → HREADY=1, HRESP=0.
- Wait states and pipeline: slave 1 holds S_HREADYOUT=0 for 3 cycles while the next address targets slave 3.
  - HREADY=0 for 3 cycles and HSEL stays 4'b1000.
  - Slave 3's data phase begins only after slave 1 completes.
- Reset mid-transfer: assert HRESET during ERR1 → next cycle HREADY=1, HRESP=0, HRDATA=0, FSM IDLE.
- Overlap priority: slaves 0 and 1 both match 0x0000_0100 → HSEL=4'b0001.
- With `KVIPS_AHB_DECMUX_TIMEOUT_EN` and TIMEOUT_CYC=8:
  - A slave stalls for 8 cycles → TIMEOUT_ERR=1 on the 8th stall cycle and stays 1 after the transfer completes.
  - A 7-cycle stall → TIMEOUT_ERR stays 0.

Source files
------------

// File: rtl/ahb_lite_decmux_if.sv
// ahb_lite_decmux_if
//   Bus bundle between the AHB-Lite master side (or arbiter output), the
//   decoder/response multiplexer and its N_SLV slaves.
//   Signals:
//     HADDR, HTRANS          master address and transfer type
//     HSEL                   one-hot slave select
//     HREADY, HRESP, HRDATA  global ready plus the response returned to the master
//     S_HREADYOUT, S_HRESP, S_HRDATA  per-slave responses, flattened by slave index
//     TIMEOUT_ERR            sticky wait-state timeout flag
//   Modports:
//     slave   the decmux's view (it consumes address and slave responses)
//     master  the environment's view (it drives address and slave responses)
interface ahb_lite_decmux_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N_SLV   = 4,
    parameter int HRESP_W = 2
);
    logic [ADDR_W-1:0]          HADDR;
    logic [1:0]                 HTRANS;
    logic [N_SLV-1:0]           HSEL;
    logic                       HREADY;
    logic [HRESP_W-1:0]         HRESP;
    logic [DATA_W-1:0]          HRDATA;
    logic [N_SLV-1:0]           S_HREADYOUT;
    logic [N_SLV*HRESP_W-1:0]   S_HRESP;
    logic [N_SLV*DATA_W-1:0]    S_HRDATA;
    logic                       TIMEOUT_ERR;

    modport slave (
        input  HADDR, HTRANS, S_HREADYOUT, S_HRESP, S_HRDATA,
        output HSEL, HREADY, HRESP, HRDATA, TIMEOUT_ERR
    );

    modport master (
        output HADDR, HTRANS, S_HREADYOUT, S_HRESP, S_HRDATA,
        input  HSEL, HREADY, HRESP, HRDATA, TIMEOUT_ERR
    );
endinterface

// File: rtl/ahb_lite_decmux.sv
// ahb_lite_decmux
//   AHB-Lite address decoder and slave-response multiplexer with a built-in
//   default slave. Decodes HADDR into a one-hot HSEL (lowest index wins on
//   overlap, no hit selects the default slave), remembers which slave owns
//   the data phase and routes that slave's response back to the master.
//   Unmapped NONSEQ/SEQ transfers get the two-cycle ERROR response.
//   Ports:
//     HCLK    clock, all state updates on the rising edge
//     HRESET  synchronous active-high reset
//     bus     ahb_lite_decmux_if.slave (address/control in, HSEL/HREADY/
//             HRESP/HRDATA/TIMEOUT_ERR out, per-slave responses in)
//   Optional feature: define KVIPS_AHB_DECMUX_TIMEOUT_EN to build the
//   wait-state counter that raises the sticky TIMEOUT_ERR after TIMEOUT_CYC
//   stalled cycles; otherwise TIMEOUT_ERR is tied low.
module ahb_lite_decmux #(
    parameter int                      ADDR_W      = 32,
    parameter int                      DATA_W      = 32,
    parameter int                      N_SLV       = 4,
    parameter int                      HRESP_W     = 2,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE    = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK    = '0,
    parameter int                      TIMEOUT_CYC = 256
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_lite_decmux_if.slave  bus
);
    // Slave indices 0..N_SLV-1; the value N_SLV denotes the default slave.
    localparam int                 SEL_W      = $clog2(N_SLV + 1);
    localparam logic [SEL_W-1:0]   DEF_IDX    = SEL_W'(N_SLV);
    localparam logic [HRESP_W-1:0] RESP_OKAY  = '0;
    localparam logic [HRESP_W-1:0] RESP_ERROR = HRESP_W'(1);

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

    logic [N_SLV-1:0]              hit;
    logic [N_SLV-1:0]              hsel;
    logic [N_SLV:0][SEL_W-1:0]     idx_chain;
    logic                          dec_def;
    logic [SEL_W-1:0]              dec_idx;

    logic [SEL_W-1:0]              dsel_q, dsel_d;
    logic                          dact_q, dact_d;
    ds_state_e                     ds_state_q, ds_state_d;

    logic [N_SLV-1:0]              dsel_oh;
    logic [N_SLV:0]                rdy_chain;
    logic [N_SLV:0][HRESP_W-1:0]   resp_chain;
    logic [N_SLV:0][DATA_W-1:0]    rdata_chain;

    logic                          hready;
    logic [HRESP_W-1:0]            hresp;
    logic [DATA_W-1:0]             hrdata;
    logic                          accept_def;

    // Address decode: priority-masked hits give a one-hot select, and an
    // OR chain turns that one-hot into the slave index.
    assign idx_chain[0] = DEF_IDX & '0;
    generate
        for (genvar gi = 0; gi < N_SLV; gi++) begin : g_dec
            assign hit[gi] = (bus.HADDR & SLV_MASK[gi*ADDR_W +: ADDR_W])
                             == SLV_BASE[gi*ADDR_W +: ADDR_W];
            if (gi == 0) begin : g_first
                assign hsel[gi] = hit[gi];
            end else begin : g_rest
                assign hsel[gi] = hit[gi] & ~(|hit[gi-1:0]);
            end
            assign idx_chain[gi+1] = idx_chain[gi] | (hsel[gi] ? SEL_W'(gi) : '0);
        end
    endgenerate

    assign dec_def = ~(|hit);
    assign dec_idx = dec_def ? DEF_IDX : idx_chain[N_SLV];

    // Response select: AND-OR mux keyed by the registered data-phase owner.
    assign rdy_chain[0]   = 1'b0;
    assign resp_chain[0]  = '0;
    assign rdata_chain[0] = '0;
    generate
        for (genvar gi = 0; gi < N_SLV; gi++) begin : g_mux
            assign dsel_oh[gi]        = (dsel_q == SEL_W'(gi));
            assign rdy_chain[gi+1]    = rdy_chain[gi] | (dsel_oh[gi] & bus.S_HREADYOUT[gi]);
            assign resp_chain[gi+1]   = resp_chain[gi]
                                        | ({HRESP_W{dsel_oh[gi]}} & bus.S_HRESP[gi*HRESP_W +: HRESP_W]);
            assign rdata_chain[gi+1]  = rdata_chain[gi]
                                        | ({DATA_W{dsel_oh[gi]}} & bus.S_HRDATA[gi*DATA_W +: DATA_W]);
        end
    endgenerate

    always_comb begin
        hready = 1'b1;
        hresp  = RESP_OKAY;
        hrdata = '0;
        if (dact_q) begin
            if (dsel_q == DEF_IDX) begin
                // First default-slave cycle stalls, second completes; both ERROR.
                hready = (ds_state_q != DS_ERR1);
                hresp  = RESP_ERROR;
            end else begin
                hready = rdy_chain[N_SLV];
                hresp  = resp_chain[N_SLV];
                hrdata = rdata_chain[N_SLV];
            end
        end
    end

    // Data-phase tracking: the pipeline only advances on HREADY.
    always_comb begin
        dsel_d = dsel_q;
        dact_d = dact_q;
        if (hready) begin
            dsel_d = dec_idx;
            dact_d = bus.HTRANS[1];
        end
    end

    // Default-slave FSM: an accepted active transfer to unmapped space
    // starts the ERROR pair, including straight from ERR2.
    assign accept_def = hready & bus.HTRANS[1] & dec_def;

    always_comb begin
        ds_state_d = ds_state_q;
        case (ds_state_q)
            DS_IDLE: if (accept_def) ds_state_d = DS_ERR1;
            DS_ERR1: ds_state_d = DS_ERR2;
            DS_ERR2: ds_state_d = accept_def ? DS_ERR1 : DS_IDLE;
            default: ds_state_d = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_q     <= '0;
            dact_q     <= 1'b0;
            ds_state_q <= DS_IDLE;
        end else begin
            dsel_q     <= dsel_d;
            dact_q     <= dact_d;
            ds_state_q <= ds_state_d;
        end
    end

`ifdef KVIPS_AHB_DECMUX_TIMEOUT_EN
    localparam int              TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_err_q, to_err_d;
    logic            to_hit;

    // The flag is shown in the very stall cycle that reaches the limit,
    // so the hit is derived from the next count rather than the registered one.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (hready) begin
            to_cnt_d = '0;
        end else if (dact_q && (to_cnt_q != TO_MAX)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        to_hit   = !hready && (to_cnt_d == TO_MAX);
        to_err_d = to_err_q | to_hit;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign bus.TIMEOUT_ERR = to_err_q | to_hit;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign bus.TIMEOUT_ERR    = 1'b0;
`endif

    // Only HTRANS[1] distinguishes active from IDLE/BUSY transfers.
    logic unused_htrans0;
    assign unused_htrans0 = bus.HTRANS[0];

    assign bus.HSEL   = hsel;
    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign bus.HRDATA = hrdata;
endmodule

// File: tb/tb_ahb_lite_decmux.sv
// tb_ahb_lite_decmux
//   Self-checking bench for ahb_lite_decmux. Directed sequences for the
//   interesting corners are followed by randomized traffic; every cycle the
//   DUT outputs are compared with a transaction-level reference model that
//   tracks which slave owns the data phase and how far the default-slave
//   ERROR has progressed.
module tb_ahb_lite_decmux;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int N_SLV   = 4;
    localparam int HRESP_W = 2;
    localparam int TO_CYC  = 8;

    // Slave 1 covers 0x0000_0000..0x1FFF_FFFF so it overlaps slave 0,
    // while 0x1xxx_xxxx still reaches slave 1 alone.
    localparam logic [N_SLV*ADDR_W-1:0] BASE = {32'h3000_0000, 32'h2000_0000,
                                                32'h0000_0000, 32'h0000_0000};
    localparam logic [N_SLV*ADDR_W-1:0] MASK = {32'hF000_0000, 32'hF000_0000,
                                                32'hE000_0000, 32'hF000_0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_lite_decmux_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV),
                         .HRESP_W(HRESP_W)) bus ();

    ahb_lite_decmux #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV), .HRESP_W(HRESP_W),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYC(TO_CYC)
    ) u_dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    bit m_act;       // a data phase is in progress
    int m_idx;       // owning slave, -1 = default slave
    int m_def_cyc;   // cycles already spent in the default-slave response
    int m_stall;     // consecutive stalled cycles of the current data phase
    bit m_terr;      // sticky timeout

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int model_decode(input logic [31:0] addr);
        logic [31:0] b, m;
        for (int i = 0; i < N_SLV; i++) begin
            b = 32'(BASE >> (32 * i));
            m = 32'(MASK >> (32 * i));
            if ((addr & m) == b) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_act = 1'b0; m_idx = 0; m_def_cyc = 0; m_stall = 0; m_terr = 1'b0;
    endtask

    task automatic do_cycle(input logic [31:0] addr, input logic [1:0] trans,
                            input logic [3:0] rdy, input logic [7:0] resp_flat,
                            input logic [127:0] rdata_flat, input bit rst_in);
        int          dec;
        logic [3:0]  exp_hsel, rdy_sh;
        logic [7:0]  resp_sh;
        logic [127:0] data_sh;
        logic        exp_rdy, exp_terr;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;

        @(posedge clk); #1;
        rst             = rst_in;
        bus.HADDR       = addr;
        bus.HTRANS      = trans;
        bus.S_HREADYOUT = rdy;
        bus.S_HRESP     = resp_flat;
        bus.S_HRDATA    = rdata_flat;
        @(negedge clk);

        dec      = model_decode(addr);
        exp_hsel = (dec >= 0) ? (4'b0001 << dec) : 4'b0000;
        if (!m_act) begin
            exp_rdy = 1'b1; exp_resp = 2'd0; exp_data = '0;
        end else if (m_idx < 0) begin
            exp_rdy = (m_def_cyc != 0); exp_resp = 2'd1; exp_data = '0;
        end else begin
            rdy_sh   = rdy >> m_idx;
            resp_sh  = resp_flat >> (2 * m_idx);
            data_sh  = rdata_flat >> (32 * m_idx);
            exp_rdy  = rdy_sh[0];
            exp_resp = resp_sh[1:0];
            exp_data = data_sh[31:0];
        end
`ifdef KVIPS_AHB_DECMUX_TIMEOUT_EN
        exp_terr = m_terr | (m_act && !exp_rdy && (m_stall + 1 >= TO_CYC));
`else
        exp_terr = 1'b0;
`endif

        check("hsel",   64'(bus.HSEL),        64'(exp_hsel));
        check("hready", 64'(bus.HREADY),      64'(exp_rdy));
        check("hresp",  64'(bus.HRESP),       64'(exp_resp));
        check("hrdata", 64'(bus.HRDATA),      64'(exp_data));
        check("terr",   64'(bus.TIMEOUT_ERR), 64'(exp_terr));

        if (!rst_in && exp_rdy && trans[1])
            $display("txn t=%0t addr=%08h trans=%0d slave=%0d", $time, addr, trans, dec);

        // Advance the model to the state after the coming rising edge.
        if (rst_in) begin
            model_reset();
        end else begin
            m_terr = exp_terr;
            if (exp_rdy) begin
                m_act = trans[1]; m_idx = dec; m_def_cyc = 0; m_stall = 0;
            end else begin
                m_def_cyc++;
                if (m_act && m_stall < TO_CYC) m_stall++;
            end
        end
    endtask

    task automatic idle_cycles(input int n, input logic [127:0] rdata);
        for (int k = 0; k < n; k++) do_cycle(32'h0, 2'b00, 4'hF, 8'h00, rdata, 1'b0);
    endtask

    initial begin
        logic [127:0] rd;
        logic [31:0]  a;
        logic [3:0]   r;
        logic [7:0]   rs;

        bus.HADDR = '0; bus.HTRANS = '0; bus.S_HREADYOUT = '1;
        bus.S_HRESP = '0; bus.S_HRDATA = '0;
        model_reset();
        repeat (3) @(posedge clk);

        // Reset state.
        idle_cycles(1, '0);

        // Decode and forward from slave 2.
        rd = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
        do_cycle(32'h2000_0040, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        idle_cycles(1, rd);

        // Unmapped NONSEQ: two-cycle ERROR, then IDLE to unmapped is OKAY.
        do_cycle(32'h8000_0000, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        idle_cycles(3, rd);
        do_cycle(32'h8000_0000, 2'b00, 4'hF, 8'h00, rd, 1'b0);
        idle_cycles(1, rd);

        // Back-to-back unmapped NONSEQ: ERR2 goes straight to a new ERR1.
        do_cycle(32'h9000_0000, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        do_cycle(32'hA000_0000, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        do_cycle(32'hA000_0000, 2'b11, 4'hF, 8'h00, rd, 1'b0);
        idle_cycles(3, rd);

        // Slave 1 stalls 3 cycles while the next address targets slave 3.
        rd = {32'hCAFE_0003, 32'h0, 32'hCAFE_0001, 32'h0};
        do_cycle(32'h1000_0000, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        for (int k = 0; k < 3; k++) do_cycle(32'h3000_0000, 2'b10, 4'b1101, 8'h00, rd, 1'b0);
        do_cycle(32'h3000_0000, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        idle_cycles(1, rd);

        // Slave two-cycle ERROR passes through unchanged.
        do_cycle(32'h2000_0000, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        do_cycle(32'h0, 2'b00, 4'b1011, 8'h10, rd, 1'b0);
        do_cycle(32'h0, 2'b00, 4'hF,    8'h10, rd, 1'b0);

        // Reset while the default slave is in its first ERROR cycle.
        do_cycle(32'h8000_0000, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        do_cycle(32'h8000_0000, 2'b10, 4'hF, 8'h00, rd, 1'b1);
        idle_cycles(2, rd);

        // Overlapping regions: the lowest index wins.
        rd = {32'h0, 32'h0, 32'hBAD0_0001, 32'h600D_0000};
        do_cycle(32'h0000_0100, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        idle_cycles(1, rd);

        // Stall lengths on either side of the timeout limit.
        do_cycle(32'h1000_0000, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        for (int k = 0; k < TO_CYC - 1; k++) do_cycle(32'h0, 2'b00, 4'b1101, 8'h00, rd, 1'b0);
        idle_cycles(2, rd);
        do_cycle(32'h1000_0000, 2'b10, 4'hF, 8'h00, rd, 1'b0);
        for (int k = 0; k < TO_CYC; k++) do_cycle(32'h0, 2'b00, 4'b1101, 8'h00, rd, 1'b0);
        idle_cycles(2, rd);
        do_cycle(32'h0, 2'b00, 4'hF, 8'h00, rd, 1'b1);
        idle_cycles(1, rd);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0: a = {4'h0, 28'($urandom)};
                1: a = {4'h1, 28'($urandom)};
                2: a = {4'h2, 28'($urandom)};
                3: a = {4'h3, 28'($urandom)};
                4: a = {4'($urandom_range(4, 15)), 28'($urandom)};
                default: a = 32'h0000_0100;
            endcase
            for (int s = 0; s < N_SLV; s++) begin
                r[s]          = ($urandom_range(0, 3) != 0);
                rs[2*s +: 2]  = ($urandom_range(0, 7) == 0) ? 2'd1 : 2'd0;
                rd[32*s +: 32] = $urandom;
            end
            do_cycle(a, 2'($urandom_range(0, 3)), r, rs, rd, ($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
